// File: rtl/led_pattern_seq.sv
// Animated pattern driver for the 8 green LEDs: prescaled step tick, debounced
// mode button, and a BLINK / ROTATE / BOUNCE pattern FSM.
module led_pattern_seq #(
   parameter int BASE_DIV     = 6_250_000,
   parameter int DEBOUNCE_CYC = 500_000
) (
   input  logic       CLOCK_50,
   input  logic       RESET,
   input  logic       KEY_MODE,
   input  logic [1:0] SPEED,
   output logic [7:0] LEDG,
   output logic [1:0] MODE
);
   localparam int PW = $clog2(BASE_DIV + 1);
   localparam int DW = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [PW-1:0] BASE    = PW'(BASE_DIV);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);

   typedef enum logic [1:0] {
      BLINK  = 2'd0,
      ROTATE = 2'd1,
      BOUNCE = 2'd2
   } mode_t;

   mode_t         state;
   logic          dir_right;
   logic [PW-1:0] cnt;
   logic [PW-1:0] limit;
   logic          tick;
   logic          key_s1, key_s2;
   logic          key_deb, key_deb_d;
   logic [DW-1:0] db_cnt;
   logic          press;
   logic [7:0]    shl, shr;

   assign limit = BASE >> SPEED;
   assign press = key_deb_d & ~key_deb;
   assign shl   = {LEDG[6:0], 1'b0};
   assign shr   = {1'b0, LEDG[7:1]};
   assign MODE  = state;

   // '>=' lets a mid-count speed-up fire on the next cycle instead of wrapping.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (press) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (cnt >= limit - PW'(1)) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt + PW'(1);
         tick <= 1'b0;
      end
   end

   // Debounced level moves only after DEBOUNCE_CYC unbroken cycles of disagreement.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         key_s1    <= 1'b1;
         key_s2    <= 1'b1;
         key_deb   <= 1'b1;
         key_deb_d <= 1'b1;
         db_cnt    <= '0;
      end else begin
         key_s1    <= KEY_MODE;
         key_s2    <= key_s1;
         key_deb_d <= key_deb;
         if (key_s2 != key_deb) begin
            if (db_cnt == DB_LAST) begin
               key_deb <= key_s2;
               db_cnt  <= '0;
            end else begin
               db_cnt <= db_cnt + DW'(1);
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         state     <= BLINK;
         LEDG      <= 8'h55;
         dir_right <= 1'b0;
      end else if (press) begin
         dir_right <= 1'b0;
         case (state)
            BLINK: begin
               state <= ROTATE;
               LEDG  <= 8'h01;
            end
            ROTATE: begin
               state <= BOUNCE;
               LEDG  <= 8'h01;
            end
            default: begin
               state <= BLINK;
               LEDG  <= 8'h55;
            end
         endcase
      end else if (tick) begin
         case (state)
            BLINK:  LEDG <= ~LEDG;
            ROTATE: LEDG <= {LEDG[6:0], LEDG[7]};
            BOUNCE: begin
               if (!dir_right) begin
                  LEDG <= shl;
                  if (shl == 8'h80) dir_right <= 1'b1;
               end else begin
                  LEDG <= shr;
                  if (shr == 8'h01) dir_right <= 1'b0;
               end
            end
            default: begin
               state <= BLINK;
               LEDG  <= 8'h55;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq: step-index reference model checked every cycle,
// directed literal checks, then randomized key/speed/reset traffic.
module tb_led_pattern_seq;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key = 1'b1;
   logic [1:0] spd = 2'd0;
   logic [7:0] ledg;
   logic [1:0] mode;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   led_pattern_seq #(.BASE_DIV(8), .DEBOUNCE_CYC(4)) dut (
      .CLOCK_50 (clk),
      .RESET    (rst),
      .KEY_MODE (key),
      .SPEED    (spd),
      .LEDG     (ledg),
      .MODE     (mode)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 20) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // LED value as a function of mode and number of steps taken since entering it.
   function automatic logic [7:0] pat(input int md, input int step);
      logic [7:0] one;
      int p;
      one = 8'h01;
      case (md)
         0: return (step % 2) ? 8'hAA : 8'h55;
         1: return one << (step % 8);
         default: begin
            p = step % 14;
            return one << ((p <= 7) ? p : 14 - p);
         end
      endcase
   endfunction

   bit m_valid = 0;
   bit m_tick, m_s1, m_s2, m_deb, m_debp, m_press;
   int m_cnt, m_dcnt, m_mode, m_step;

   always @(posedge clk) begin
      if (rst) begin
         m_valid = 1; m_tick = 0; m_cnt = 0;
         m_s1 = 1; m_s2 = 1; m_deb = 1; m_debp = 1; m_dcnt = 0;
         m_mode = 0; m_step = 0;
      end else begin
         m_press = m_debp && !m_deb;
         if (m_press) begin
            m_mode = (m_mode + 1) % 3;
            m_step = 0;
            m_cnt  = 0;
            m_tick = 0;
         end else begin
            if (m_tick) m_step++;
            if (m_cnt >= (8 >> spd) - 1) begin
               m_cnt = 0; m_tick = 1;
            end else begin
               m_cnt++; m_tick = 0;
            end
         end
         m_debp = m_deb;
         if (m_s2 != m_deb) begin
            if (m_dcnt == 3) begin
               m_deb = m_s2; m_dcnt = 0;
            end else m_dcnt++;
         end else m_dcnt = 0;
         m_s2 = m_s1;
         m_s1 = key;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_ledg", 32'(ledg), 32'(pat(m_mode, m_step)));
         chk("model_mode", 32'(mode), 32'(m_mode));
      end
   end

   logic [7:0] bseq [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                             8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

   initial begin
      // reset and blink
      rst = 1; cyc(3); rst = 0;
      chk("reset_ledg", 32'(ledg), 32'h55);
      chk("reset_mode", 32'(mode), 32'd0);
      cyc(8); chk("blink_hold", 32'(ledg), 32'h55);
      cyc(1); chk("blink_aa", 32'(ledg), 32'hAA);
      cyc(8); chk("blink_55", 32'(ledg), 32'h55);

      // long hold gives exactly one press
      key = 0;
      cyc(6); chk("press_early", 32'(mode), 32'd0);
      cyc(1); chk("press_mode", 32'(mode), 32'd1);
      chk("press_ledg", 32'(ledg), 32'h01);
      cyc(8); chk("rotate_hold", 32'(ledg), 32'h01);
      cyc(1); chk("rotate_02", 32'(ledg), 32'h02);
      cyc(4); key = 1;
      cyc(40); chk("held_mode", 32'(mode), 32'd1);

      // short glitches are rejected
      repeat (5) begin
         key = 0; cyc(2); key = 1; cyc(6);
      end
      chk("glitch_mode", 32'(mode), 32'd1);

      // press coincident with a tick (SPEED=3 ticks every cycle), then bounce walk
      spd = 3; cyc(3);
      key = 0; cyc(7);
      chk("bounce_mode", 32'(mode), 32'd2);
      chk("bounce_entry", 32'(ledg), 32'h01);
      for (int i = 0; i < 16; i++) begin
         cyc(1); chk("bounce_seq", 32'(ledg), 32'(bseq[i]));
      end
      cyc(7); chk("bounce_right", 32'(ledg), 32'h40);

      // reset mid-bounce while moving right
      rst = 1; key = 1; cyc(1);
      chk("midreset_ledg", 32'(ledg), 32'h55);
      chk("midreset_mode", 32'(mode), 32'd0);
      rst = 0; spd = 0;

      // speed raised with cnt past the new limit
      cyc(5); spd = 2;
      cyc(1); chk("spd_e6", 32'(ledg), 32'h55);
      cyc(1); chk("spd_e7", 32'(ledg), 32'hAA);
      cyc(1); chk("spd_e8", 32'(ledg), 32'hAA);
      cyc(1); chk("spd_e9", 32'(ledg), 32'h55);
      cyc(1); chk("spd_e10", 32'(ledg), 32'h55);
      cyc(1); chk("spd_e11", 32'(ledg), 32'hAA);

      // randomized traffic against the model
      repeat (150) begin
         if ($urandom_range(0, 3) == 0) spd = 2'($urandom_range(0, 3));
         key = 0; cyc(int'($urandom_range(1, 12)));
         key = 1; cyc(int'($urandom_range(1, 30)));
         if ($urandom_range(0, 40) == 0) begin
            rst = 1; cyc(int'($urandom_range(1, 3))); rst = 0;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
